// File: rtl/icache_responder_pkg.sv
// Shared types and line geometry for the direct-mapped instruction cache.
package icache_responder_pkg;

    localparam int unsigned LINE_BYTES  = 32;
    localparam int unsigned BEAT_BITS   = 64;
    localparam int unsigned BEATS       = 4;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned LINE_BITS   = LINE_BYTES * 8;
    localparam int unsigned WORD_BITS   = 32;

    typedef enum logic [1:0] {StIdle, StFill, StDrain, StResp} state_e;

    function automatic logic [WORD_BITS-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                       input logic [2:0] sel);
        return line[32'(sel) * WORD_BITS +: WORD_BITS];
    endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side request/response and memory burst signals of the instruction cache.
interface icache_responder_if;
    import icache_responder_pkg::*;

    logic [31:0]           cache_addr;
    logic [3:0]            cache_rmask;
    logic [WORD_BITS-1:0]  cache_rdata;
    logic [LINE_BITS-1:0]  cache_rdata_line;
    logic                  cache_resp;
    logic                  flush;
    logic [31:0]           mem_addr;
    logic                  mem_read;
    logic [BEAT_BITS-1:0]  mem_rdata;
    logic                  mem_rvalid;

    modport master (
        output cache_addr, cache_rmask, flush, mem_rdata, mem_rvalid,
        input  cache_rdata, cache_rdata_line, cache_resp, mem_addr, mem_read
    );

    modport slave (
        input  cache_addr, cache_rmask, flush, mem_rdata, mem_rvalid,
        output cache_rdata, cache_rdata_line, cache_resp, mem_addr, mem_read
    );

endinterface

// File: rtl/icache_fill_buffer.sv
// Beat counter and line assembly register for a 4-beat refill burst.
module icache_fill_buffer
    import icache_responder_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 beat_valid_i,
    input  logic [BEAT_BITS-1:0] beat_data_i,
    output logic                 line_done_o,
    output logic [LINE_BITS-1:0] line_o
);

    localparam int unsigned CntBits = $clog2(BEATS);

    logic [CntBits-1:0]   cnt_q, cnt_d;
    logic [LINE_BITS-1:0] line_q, line_d;

    // line_o includes the beat arriving this cycle so the last beat can be written directly.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (beat_valid_i) begin
            cnt_d = cnt_q + 1'b1;
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (cnt_q == CntBits'(k)) begin
                    line_d[k * BEAT_BITS +: BEAT_BITS] = beat_data_i;
                end
            end
        end
    end

    assign line_done_o = beat_valid_i && (cnt_q == CntBits'(BEATS - 1));
    assign line_o      = line_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        line_q <= line_d;
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: registered hit response, 4-beat refill on miss.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int unsigned SETS = 16
) (
    input  logic               clk,
    input  logic               rst,
    icache_responder_if.slave  bus
);

    localparam int unsigned IndexBits    = $clog2(SETS);
    localparam int unsigned LineAddrBits = 32 - OFFSET_BITS;
    localparam int unsigned TagBits      = LineAddrBits - IndexBits;

    state_e                  state_q, state_d;
    logic [LineAddrBits-1:0] line_addr_q, line_addr_d;
    logic [WORD_BITS-1:0]    rdata_q, rdata_d;
    logic [LINE_BITS-1:0]    line_out_q, line_out_d;
    logic                    resp_q, resp_d;
    logic                    mem_read_q, mem_read_d;
    logic                    flush_seen_q, flush_seen_d;

    logic [SETS-1:0]         valid_q;
    logic [TagBits-1:0]      tag_q  [SETS];
    logic [LINE_BITS-1:0]    data_q [SETS];

    logic [IndexBits-1:0]    req_idx, fill_idx;
    logic [TagBits-1:0]      req_tag, fill_tag;
    logic [2:0]              word_sel;
    logic                    req_valid, hit;
    logic                    beat_valid, line_done, fill_start, fill_write;
    logic [LINE_BITS-1:0]    fill_line;
    logic                    unused_addr_bits;

    assign req_idx   = bus.cache_addr[OFFSET_BITS +: IndexBits];
    assign req_tag   = bus.cache_addr[31 -: TagBits];
    assign word_sel  = bus.cache_addr[OFFSET_BITS-1:2];
    assign fill_idx  = line_addr_q[IndexBits-1:0];
    assign fill_tag  = line_addr_q[LineAddrBits-1 -: TagBits];
    assign req_valid = |bus.cache_rmask;
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign beat_valid = (state_q == StFill) && bus.mem_rvalid;
    assign unused_addr_bits = ^bus.cache_addr[1:0];

    icache_fill_buffer u_fill_buffer (
        .clk_i        (clk),
        .rst_ni       (rst),
        .start_i      (fill_start),
        .beat_valid_i (beat_valid),
        .beat_data_i  (bus.mem_rdata),
        .line_done_o  (line_done),
        .line_o       (fill_line)
    );

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        rdata_d      = rdata_q;
        line_out_d   = line_out_q;
        resp_d       = 1'b0;
        mem_read_d   = mem_read_q;
        flush_seen_d = flush_seen_q;
        fill_start   = 1'b0;
        fill_write   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A request still held during its own response cycle is not re-accepted.
                if (req_valid && !resp_q) begin
                    if (hit) begin
                        resp_d     = 1'b1;
                        line_out_d = data_q[req_idx];
                        rdata_d    = line_word(data_q[req_idx], word_sel);
                    end else begin
                        line_addr_d  = bus.cache_addr[31:OFFSET_BITS];
                        mem_read_d   = 1'b1;
                        fill_start   = 1'b1;
                        flush_seen_d = 1'b0;
                        state_d      = StFill;
                    end
                end
            end
            StFill: begin
                if (bus.flush) flush_seen_d = 1'b1;
                if (line_done) begin
                    mem_read_d = 1'b0;
                    if (flush_seen_q || bus.flush) begin
                        state_d = StDrain;
                    end else begin
                        fill_write = 1'b1;
                        resp_d     = 1'b1;
                        line_out_d = fill_line;
                        rdata_d    = line_word(fill_line, word_sel);
                        state_d    = StResp;
                    end
                end
            end
            StDrain: state_d = StIdle;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            line_addr_q  <= '0;
            rdata_q      <= '0;
            line_out_q   <= '0;
            resp_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            rdata_q      <= rdata_d;
            line_out_q   <= line_out_d;
            resp_q       <= resp_d;
            mem_read_q   <= mem_read_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            valid_q <= '0;
        end else if (fill_write) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_write) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_line;
        end
    end

    assign bus.cache_rdata      = rdata_q;
    assign bus.cache_rdata_line = line_out_q;
    assign bus.cache_resp       = resp_q;
    assign bus.mem_read         = mem_read_q;
    assign bus.mem_addr         = {line_addr_q, {OFFSET_BITS{1'b0}}};

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: directed requests push expected responses,
// a negedge monitor pops and compares every cache_resp pulse.
module tb_icache_responder;

    typedef struct packed {
        logic [31:0]  rdata;
        logic [255:0] line;
    } resp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    resp_t exp_q[$];
    logic  prev_resp = 1'b0;

    icache_responder_if bus ();

    icache_responder #(.SETS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] LineA = {64'h44444444_04040404, 64'h33333333_03030303,
                                      64'h22222222_02020202, 64'h11111111_01010101};
    localparam logic [255:0] LineB = {64'h88888888_08080808, 64'h77777777_07070707,
                                      64'h66666666_06060606, 64'h55555555_05050505};
    localparam logic [255:0] LineC = {64'hcccccccc_0c0c0c0c, 64'hbbbbbbbb_0b0b0b0b,
                                      64'haaaaaaaa_0a0a0a0a, 64'h99999999_09090909};
    localparam logic [255:0] LineD = {64'hdddd0003_d0d00003, 64'hdddd0002_d0d00002,
                                      64'hdddd0001_d0d00001, 64'hdddd0000_d0d00000};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] w, input logic [255:0] line);
        resp_t e;
        e.rdata = w;
        e.line  = line;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.cache_resp) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=1 required=0");
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", bus.cache_rdata, e.rdata);
                chk("resp_line", bus.cache_rdata_line, e.line);
            end
            chk("no_double_pulse", prev_resp, 1'b0);
        end
        prev_resp = bus.cache_resp;
    end

    // Miss with refill; optionally holds the request so a hit follows the fill response.
    task automatic do_miss(input logic [31:0] addr, input logic [255:0] line, input int gap,
                           input bit hold);
        logic [31:0] w;
        w = line[int'(addr[4:2]) * 32 +: 32];
        bus.cache_addr  = addr;
        bus.cache_rmask = 4'hf;
        push_exp(w, line);
        if (hold) push_exp(w, line);
        tick;
        chk("miss_mem_read", bus.mem_read, 1'b1);
        chk("miss_mem_addr", bus.mem_addr, {addr[31:5], 5'b0});
        repeat (gap) tick;
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = line[k * 64 +: 64];
            tick;
        end
        bus.mem_rvalid = 1'b0;
        chk("fill_mem_read_drop", bus.mem_read, 1'b0);
        chk("miss_resp_latency", bus.cache_resp, 1'b1);
        tick;
        if (hold) begin
            chk("b2b_gap", bus.cache_resp, 1'b0);
            tick;
            chk("b2b_second_resp", bus.cache_resp, 1'b1);
            tick;
        end
        bus.cache_rmask = 4'h0;
        chk("resp_single_cycle", bus.cache_resp, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b0;
        bus.cache_addr  = '0;
        bus.cache_rmask = '0;
        bus.flush       = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rvalid  = 1'b0;
        tick;
        tick;
        chk("rst_resp", bus.cache_resp, 1'b0);
        chk("rst_rdata", bus.cache_rdata, 32'h0);
        chk("rst_line", bus.cache_rdata_line, 256'h0);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b1;
        tick;

        // Cold miss, memory answers after 3 idle cycles
        do_miss(32'h0000_1004, LineA, 3, 1'b0);

        // Hit; a stray mem_rvalid in IDLE must be ignored
        bus.cache_addr  = 32'h0000_101c;
        bus.cache_rmask = 4'hf;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = 64'hdead_beef_dead_beef;
        push_exp(32'h44444444, LineA);
        tick;
        bus.mem_rvalid = 1'b0;
        chk("hit_latency", bus.cache_resp, 1'b1);
        chk("hit_no_mem_read", bus.mem_read, 1'b0);
        tick;
        chk("hit_held_no_repeat", bus.cache_resp, 1'b0);
        bus.cache_rmask = 4'h0;
        tick;

        // Conflict: same index, different tag, then the evicted line misses again
        do_miss(32'h0000_1208, LineB, 0, 1'b0);
        tick;
        do_miss(32'h0000_1000, LineA, 1, 1'b0);
        tick;

        // Flush during a fill: burst completes, no response, line left invalid
        bus.cache_addr  = 32'h0000_2000;
        bus.cache_rmask = 4'hf;
        tick;
        chk("flush_fill_mem_read", bus.mem_read, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = LineC[k * 64 +: 64];
            bus.flush      = (k == 1);
            tick;
        end
        bus.mem_rvalid  = 1'b0;
        bus.flush       = 1'b0;
        bus.cache_rmask = 4'h0;
        chk("flush_mem_read_drop", bus.mem_read, 1'b0);
        chk("flush_no_resp", bus.cache_resp, 1'b0);
        tick;
        chk("drain_no_resp", bus.cache_resp, 1'b0);
        tick;
        do_miss(32'h0000_2000, LineC, 2, 1'b0);
        tick;

        // Reset after beat 2: fill abandoned, trailing beat ignored
        bus.cache_addr  = 32'h0000_3004;
        bus.cache_rmask = 4'hf;
        tick;
        chk("rstfill_mem_read", bus.mem_read, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = LineD[k * 64 +: 64];
            tick;
        end
        bus.mem_rvalid  = 1'b0;
        bus.cache_rmask = 4'h0;
        rst             = 1'b0;
        tick;
        rst = 1'b1;
        chk("rstfill_mem_read_drop", bus.mem_read, 1'b0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = LineD[192 +: 64];
        tick;
        bus.mem_rvalid = 1'b0;
        chk("rstfill_late_beat_mem_read", bus.mem_read, 1'b0);
        chk("rstfill_late_beat_resp", bus.cache_resp, 1'b0);

        // Refetch after reset, request held through the response (back-to-back)
        do_miss(32'h0000_3004, LineD, 0, 1'b1);
        tick;
        tick;

        chk("scoreboard_drained", 256'(exp_q.size()), 256'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
